// File: rtl/crossbar_arbiter.sv
// rtl/crossbar_arbiter.sv - per-slave round-robin arbiter driving crossbar select arrays
module crossbar_arbiter #(
  parameter int M  = 3,
  parameter int S  = 2,
  parameter int TO = 256
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [M-1:0]                    m_req_i,
  input  logic [M-1:0][$clog2(S)-1:0]     m_tgt_i,
  input  logic [M-1:0]                    m_done_i,
  output logic [M-1:0]                    m_gnt_o,
  output logic [M-1:0][$clog2(S)-1:0]     s_sel_array_o,
  output logic [S-1:0][$clog2(M)-1:0]     m_sel_array_o,
  output logic [S-1:0]                    s_active_o,
  output logic [S-1:0]                    s_timeout_o
);

  localparam int TW = $clog2(S);
  localparam int MW = $clog2(M);
  // TO=0 disables the timeout; keep a 1-bit counter so widths stay legal.
  localparam int CW = (TO > 0) ? $clog2(TO + 1) : 1;
  localparam int unsigned TO_M1 = (TO > 0) ? TO - 1 : 0;
  localparam logic [CW-1:0] CNT_MAX = CW'(TO_M1);
  localparam logic [MW-1:0] PTR_RST = MW'(M - 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_e;

  state_e                  state_q [S];
  state_e                  state_d [S];
  logic [S-1:0][MW-1:0]    owner_q, owner_d;
  logic [S-1:0][MW-1:0]    ptr_q, ptr_d;
  logic [S-1:0][CW-1:0]    cnt_q, cnt_d;
  logic [S-1:0]            tmo_q, tmo_d;
  logic [M-1:0]            gnt_q, gnt_d;
  logic [M-1:0][TW-1:0]    ssel_q, ssel_d;
  logic [M-1:0][S-1:0]     elig;

  logic                    found;
  logic [MW-1:0]           pick;
  logic [MW-1:0]           own;
  logic                    tmo_hit;
  int                      idx;

  // Eligibility: requesting, not already granted, and targeting slave j.
  // Matching against j < S also rejects out-of-range targets.
  always_comb begin
    elig = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < S; j++) begin
        elig[i][j] = m_req_i[i] && !gnt_q[i] && (int'(m_tgt_i[i]) == j);
      end
    end
  end

  // Per-slave next state: round-robin pick in IDLE, release checks in GRANT,
  // then rebuild the master-side grant/select view from the next state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    found   = 1'b0;
    pick    = '0;
    own     = '0;
    tmo_hit = 1'b0;
    idx     = 0;
    for (int j = 0; j < S; j++) begin
      found   = 1'b0;
      pick    = '0;
      own     = owner_q[j];
      tmo_hit = 1'b0;
      case (state_q[j])
        ST_IDLE: begin
          for (int off = 1; off <= M; off++) begin
            idx = (int'(ptr_q[j]) + off) % M;
            if (!found && elig[idx][j]) begin
              found = 1'b1;
              pick  = MW'(idx);
            end
          end
          if (found) begin
            state_d[j] = ST_GRANT;
            owner_d[j] = pick;
            cnt_d[j]   = '0;
          end
        end
        default: begin
          tmo_hit = (TO != 0) && (cnt_q[j] == CNT_MAX);
          if (m_done_i[own] || !m_req_i[own] || tmo_hit) begin
            state_d[j] = ST_IDLE;
            ptr_d[j]   = own;
            owner_d[j] = '0;
            cnt_d[j]   = '0;
            // A completion in the same cycle is a normal finish, not a timeout.
            tmo_d[j]   = tmo_hit && !m_done_i[own];
          end else if (TO != 0) begin
            // Release fires at CNT_MAX, so the counter never passes it.
            cnt_d[j] = cnt_q[j] + 1'b1;
          end
        end
      endcase
    end
    gnt_d  = '0;
    ssel_d = '0;
    for (int j = 0; j < S; j++) begin
      if (state_d[j] == ST_GRANT) begin
        gnt_d[owner_d[j]]  = 1'b1;
        ssel_d[owner_d[j]] = TW'(j);
      end
    end
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < S; j++) begin
        state_q[j] <= ST_IDLE;
      end
      owner_q <= '0;
      ptr_q   <= {S{PTR_RST}};
      cnt_q   <= '0;
      tmo_q   <= '0;
      gnt_q   <= '0;
      ssel_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      gnt_q   <= gnt_d;
      ssel_q  <= ssel_d;
    end
  end

  // Slave-side enables decode straight from the state registers.
  always_comb begin
    for (int j = 0; j < S; j++) begin
      s_active_o[j] = (state_q[j] == ST_GRANT);
    end
  end

  assign m_gnt_o       = gnt_q;
  assign s_sel_array_o = ssel_q;
  assign m_sel_array_o = owner_q;
  assign s_timeout_o   = tmo_q;

endmodule
